// File: rtl/spi_pkg.sv
// Shared types and default parameters for the SPI slave receiver.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } rx_state_t;

    localparam int SPI_DATA_W_DEF      = 8;
    localparam int SPI_SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/spi_sync.sv
// N-flop synchronizer for one asynchronous input, with a selectable reset value.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift the raw input through the synchronizer chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= {STAGES{RST_VAL}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver: oversampled sclk/cs/mosi, MSB-first words on a valid/ready port.
// Optional transmit path (tx_data/miso) is built when SPI_SLV_MISO_EN is defined.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W_DEF,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
`ifdef SPI_SLV_MISO_EN
    input  logic [DATA_W-1:0] tx_data,
    output logic              miso,
`endif
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    logic              sclk_s, cs_s, mosi_s;
    logic              sclk_d_r;
    logic              sclk_rise_s;
    rx_state_t         state_r, state_nxt_s;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [DATA_W-1:0] shift_r, shift_nxt_s;
    logic [DATA_W-1:0] rx_data_r;
    logic              rx_valid_r, frame_err_r, overrun_r;
    logic              word_done_s, frame_abort_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst(rst), .d(cs),   .q(cs_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d(mosi), .q(mosi_s));

    assign sclk_rise_s = sclk_s & ~sclk_d_r;
    assign shift_nxt_s = {shift_r[DATA_W-2:0], mosi_s};

    // Next state plus word-complete and aborted-frame decode
    always_comb begin
        state_nxt_s   = state_r;
        word_done_s   = 1'b0;
        frame_abort_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!cs_s) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                word_done_s = sclk_rise_s && (bit_cnt_r == CNT_W'(DATA_W - 1));
                if (cs_s) begin
                    state_nxt_s   = IDLE;
                    frame_abort_s = (bit_cnt_r != {CNT_W{1'b0}}) && !word_done_s;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register, sclk edge history and bit shifting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            sclk_d_r  <= 1'b0;
            bit_cnt_r <= {CNT_W{1'b0}};
            shift_r   <= {DATA_W{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            sclk_d_r <= sclk_s;
            if (state_r != SHIFT) begin
                bit_cnt_r <= {CNT_W{1'b0}};
            end else if (cs_s && !word_done_s) begin
                // frame ended: drop any partial word
                bit_cnt_r <= {CNT_W{1'b0}};
                shift_r   <= {DATA_W{1'b0}};
            end else if (sclk_rise_s) begin
                shift_r   <= shift_nxt_s;
                bit_cnt_r <= word_done_s ? {CNT_W{1'b0}} : bit_cnt_r + CNT_W'(1);
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
        end
    end

    // Output handshake, overrun and framing-error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data_r   <= {DATA_W{1'b0}};
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            frame_err_r <= frame_abort_s;
            overrun_r   <= 1'b0;
            if (word_done_s) begin
                if (!rx_valid_r || rx_ready) begin
                    rx_data_r  <= shift_nxt_s;
                    rx_valid_r <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (rx_valid_r && rx_ready) begin
                rx_valid_r <= 1'b0;
            end else begin
                rx_valid_r <= rx_valid_r;
            end
        end
    end

    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;

`ifdef SPI_SLV_MISO_EN
    logic [DATA_W-1:0] tx_shift_r;
    logic              sclk_fall_s;

    assign sclk_fall_s = ~sclk_s & sclk_d_r;

    // Transmit shifter: load at frame start and word end, advance on sclk fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift_r <= {DATA_W{1'b0}};
        end else if (state_r == IDLE) begin
            tx_shift_r <= (!cs_s) ? tx_data : {DATA_W{1'b0}};
        end else if (cs_s) begin
            tx_shift_r <= {DATA_W{1'b0}};
        end else if (word_done_s) begin
            tx_shift_r <= tx_data;
        end else if (sclk_fall_s) begin
            tx_shift_r <= {tx_shift_r[DATA_W-2:0], 1'b0};
        end else begin
            tx_shift_r <= tx_shift_r;
        end
    end

    assign miso = tx_shift_r[DATA_W-1];
`endif

endmodule
